dlx_ex_issue: RTL and testbench
===============================

Name: dlx_ex_issue

Overview:
- Execute-stage front end and back end wrapped around the combinational arithmetic ALU (alu_arith) of the DLX integer pipeline.
- Accepts a decoded instruction from ID and decodes it into the ALU select lines sel0..sel4.
- Registers the operands into the ALU, then captures the ALU result into an EX/MEM output register.
- Uses valid/ready backpressure and flush on both sides.

Parameters:
- DW, 32, datapath width (operands and result).
- RW, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- flush  input  1  kill all in-flight ops (branch/exception)
- in_valid  input  1  ID presents an instruction
- in_ready  output  1  block accepts this cycle
- opcode  input  6  DLX primary opcode
- func  input  6  DLX R-type function field
- rs1_val  input  DW  source operand 1
- rs2_val  input  DW  source operand 2 (R-type)
- imm16  input  16  I-type immediate
- rd  input  RW  destination register
- alu_in1  output  DW  to ALU in1
- alu_in2  output  DW  to ALU in2
- alu_sel  output  5  {sel4,sel3,sel2,sel1,sel0} to ALU
- alu_out  input  DW  ALU result
- alu_overflow  input  1  ALU overflow
- out_valid  output  1  EX/MEM result valid
- out_ready  input  1  MEM accepts
- out_result  output  DW  captured result
- out_rd  output  RW  captured destination
- out_overflow  output  1  signed-overflow trap flag
- out_illegal  output  1  unsupported opcode/func

Behaviour:
- Reset: when rst_n=0 at a clk edge, all registers clear. out_valid=0, out_result=0, out_rd=0, out_overflow=0, out_illegal=0, alu_in1=0, alu_in2=0, alu_sel=5'b00000 (ADD). in_ready=1 in the cycle after reset.
- Select encoding {sel4,sel3,sel2,sel1,sel0}:
  - ADD 00000, SUB 11000
  - SEQ 10000, SNE 10001, SLT 10010, SGT 10011, SLE 10100, SGE 10110
- R-type (opcode 0x00) func decode:
  - 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU
  - 0x28 SEQ, 0x29 SNE, 0x2A SLT, 0x2B SGT, 0x2C SLE, 0x2D SGE
  - alu_in2 = rs2_val.
- I-type decode:
  - 0x08 ADDI, 0x09 ADDUI, 0x0A SUBI, 0x0B SUBUI
  - 0x18 SEQI, 0x19 SNEI, 0x1A SLTI, 0x1B SGTI, 0x1C SLEI, 0x1D SGEI
  - alu_in2 = sign-extended imm16; zero-extended for ADDUI/SUBUI.
- alu_in1 = rs1_val in all cases.
- Unsupported opcode/func: op is still accepted and executes as ADD; illegal bit travels with the op.
- Overflow masking: alu_overflow is sampled only for signed ADD/SUB/ADDI/SUBI. Forced to 0 for unsigned and set ops.
- Pipeline: stage S1 is the operand/select register feeding the ALU; stage S2 is the output register.
  - Accept at edge N → operands on ALU during cycle N+1 → out_valid=1 from edge N+1 onward.
  - Latency 2 edges, one result per cycle throughput.
- Handshakes:
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free (combinational).
  - S1→S2 transfer when s1_valid && s2_free.
  - While stalled, alu_in1, alu_in2, alu_sel and all out_* hold stable.
  - out_* stable while out_valid && !out_ready.
  - S2 updates on simultaneous drain and transfer (full-rate flow).
- Flush:
  - At the edge with flush=1, s1_valid and out_valid clear.
  - Any same-cycle in_valid&&in_ready handshake is discarded; flush wins.
  - Data registers may keep stale values.
- Reset mid-operation: in-flight ops are lost, with no partial output.

Decomposition:
- Shared package dlx_pkg holds:
  - opcode/func localparams
  - the 5-bit ALU select constants (SEL_ADD … SEL_SGE)
  - DW/RW defaults
- One sub-module, dlx_alu_dec: purely combinational opcode/func → {sel, imm_zext, use_imm, chk_ovf, illegal}.
- Handshake and registers stay in dlx_ex_issue.

Test Plan:
- R-type ADD, rs1=1, rs2=1, out_ready=1 → alu_sel=00000 one cycle after accept; out_result=2, out_valid=1 two edges after accept, flags 0.
- SGE sequence SEQ/SNE/SLT/SGT/SLE/SGE with rs1=rs2=1, back-to-back → alu_sel 10000, 10001, 10010, 10011, 10100, 10110 in order; results 1,0,0,0,1,1 on consecutive cycles.
- ADDI rs1=0x7FFFFFFF, imm16=0x0001 → out_overflow=1. ADDUI same operands → out_overflow=0. SUBUI imm16=0xFFFF → alu_in2=0x0000FFFF.
- Backpressure: out_ready=0 for 3 cycles with 3 ops offered → first op held on out_*. in_ready drops after the second accept. Release gives in-order results, none lost or duplicated.
- Flush asserted with ops in S1 and S2 plus a same-cycle in_valid → next cycle out_valid=0 and S1 empty. The flushed op never appears.
- opcode=0x3F → out_illegal=1, out_result=rs1+imm. Assert rst_n=0 mid-stream → all outputs zero on the next edge.

Source files
------------

// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dlx_pkg
// Purpose  : Shared constants and types for the DLX execute-stage issue logic:
//            opcode/func codes, ALU select encodings, default widths.
// Revision : 1.0 - initial release
// ============================================================================
package dlx_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int RW_DEFAULT = 5;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_SUBUI = 6'h0B;
  localparam logic [5:0] OP_SEQI  = 6'h18;
  localparam logic [5:0] OP_SNEI  = 6'h19;
  localparam logic [5:0] OP_SLTI  = 6'h1A;
  localparam logic [5:0] OP_SGTI  = 6'h1B;
  localparam logic [5:0] OP_SLEI  = 6'h1C;
  localparam logic [5:0] OP_SGEI  = 6'h1D;

  // R-type function codes
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SEQ  = 6'h28;
  localparam logic [5:0] FN_SNE  = 6'h29;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SGT  = 6'h2B;
  localparam logic [5:0] FN_SLE  = 6'h2C;
  localparam logic [5:0] FN_SGE  = 6'h2D;

  // ALU select lines {sel4,sel3,sel2,sel1,sel0}
  localparam logic [4:0] SEL_ADD = 5'b00000;
  localparam logic [4:0] SEL_SUB = 5'b11000;
  localparam logic [4:0] SEL_SEQ = 5'b10000;
  localparam logic [4:0] SEL_SNE = 5'b10001;
  localparam logic [4:0] SEL_SLT = 5'b10010;
  localparam logic [4:0] SEL_SGT = 5'b10011;
  localparam logic [4:0] SEL_SLE = 5'b10100;
  localparam logic [4:0] SEL_SGE = 5'b10110;

  // Decoded control bundle produced from opcode/func
  typedef struct packed {
    logic [4:0] sel;
    logic       imm_zext;
    logic       use_imm;
    logic       chk_ovf;
    logic       illegal;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/dlx_alu_dec.sv
`default_nettype none
// ============================================================================
// Module   : dlx_alu_dec
// Purpose  : Combinational opcode/func decode into ALU select and operand
//            control. Unsupported encodings fall back to ADD and flag illegal.
// Revision : 1.0 - initial release
// ============================================================================
module dlx_alu_dec import dlx_pkg::*; (
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output dec_t       dec_o
);

  // Decode instruction fields; defaults describe a plain register ADD
  always_comb begin
    dec_o          = '0;
    dec_o.sel      = SEL_ADD;
    if (opcode_i == OP_RTYPE) begin
      unique case (func_i)
        FN_ADD:  dec_o.chk_ovf = 1'b1;
        FN_ADDU: dec_o.sel     = SEL_ADD;
        FN_SUB:  begin dec_o.sel = SEL_SUB; dec_o.chk_ovf = 1'b1; end
        FN_SUBU: dec_o.sel     = SEL_SUB;
        FN_SEQ:  dec_o.sel     = SEL_SEQ;
        FN_SNE:  dec_o.sel     = SEL_SNE;
        FN_SLT:  dec_o.sel     = SEL_SLT;
        FN_SGT:  dec_o.sel     = SEL_SGT;
        FN_SLE:  dec_o.sel     = SEL_SLE;
        FN_SGE:  dec_o.sel     = SEL_SGE;
        default: dec_o.illegal = 1'b1;
      endcase
    end else begin
      // Every non-R-type op, legal or not, takes its second operand from imm16
      dec_o.use_imm = 1'b1;
      unique case (opcode_i)
        OP_ADDI:  dec_o.chk_ovf = 1'b1;
        OP_ADDUI: dec_o.imm_zext = 1'b1;
        OP_SUBI:  begin dec_o.sel = SEL_SUB; dec_o.chk_ovf = 1'b1; end
        OP_SUBUI: begin dec_o.sel = SEL_SUB; dec_o.imm_zext = 1'b1; end
        OP_SEQI:  dec_o.sel = SEL_SEQ;
        OP_SNEI:  dec_o.sel = SEL_SNE;
        OP_SLTI:  dec_o.sel = SEL_SLT;
        OP_SGTI:  dec_o.sel = SEL_SGT;
        OP_SLEI:  dec_o.sel = SEL_SLE;
        OP_SGEI:  dec_o.sel = SEL_SGE;
        default:  dec_o.illegal = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dlx_ex_issue.sv
`default_nettype none
// ============================================================================
// Module   : dlx_ex_issue
// Purpose  : Execute-stage wrapper around the external arithmetic ALU.
//            S1 registers operands/select toward the ALU, S2 captures the
//            ALU result for EX/MEM. Valid/ready on both sides, plus flush.
// Revision : 1.0 - initial release
// ============================================================================
module dlx_ex_issue import dlx_pkg::*; #(
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    opcode,
  input  logic [5:0]    func,
  input  logic [DW-1:0] rs1_val,
  input  logic [DW-1:0] rs2_val,
  input  logic [15:0]   imm16,
  input  logic [RW-1:0] rd,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [4:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_overflow,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_overflow,
  output logic          out_illegal
);

  dec_t          w_dec;
  logic [DW-1:0] w_imm_ext;
  logic          w_s2_free;
  logic          w_accept;
  logic          w_xfer;

  // S1: operands and select presented to the ALU
  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_in1_q,   s1_in1_d;
  logic [DW-1:0] s1_in2_q,   s1_in2_d;
  logic [4:0]    s1_sel_q,   s1_sel_d;
  logic [RW-1:0] s1_rd_q,    s1_rd_d;
  logic          s1_chk_q,   s1_chk_d;
  logic          s1_ill_q,   s1_ill_d;

  // S2: EX/MEM output register
  logic          s2_valid_q, s2_valid_d;
  logic [DW-1:0] s2_res_q,   s2_res_d;
  logic [RW-1:0] s2_rd_q,    s2_rd_d;
  logic          s2_ovf_q,   s2_ovf_d;
  logic          s2_ill_q,   s2_ill_d;

  dlx_alu_dec u_dec (
    .opcode_i (opcode),
    .func_i   (func),
    .dec_o    (w_dec)
  );

  assign w_imm_ext = w_dec.imm_zext ? {{(DW-16){1'b0}}, imm16}
                                    : {{(DW-16){imm16[15]}}, imm16};

  assign w_s2_free = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || w_s2_free;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = s1_valid_q && w_s2_free;

  // Next-state for both stages; flush overrides only the valid bits
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_in1_d   = s1_in1_q;
    s1_in2_d   = s1_in2_q;
    s1_sel_d   = s1_sel_q;
    s1_rd_d    = s1_rd_q;
    s1_chk_d   = s1_chk_q;
    s1_ill_d   = s1_ill_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_rd_d    = s2_rd_q;
    s2_ovf_d   = s2_ovf_q;
    s2_ill_d   = s2_ill_q;

    if (w_accept) begin
      s1_valid_d = 1'b1;
      s1_in1_d   = rs1_val;
      s1_in2_d   = w_dec.use_imm ? w_imm_ext : rs2_val;
      s1_sel_d   = w_dec.sel;
      s1_rd_d    = rd;
      s1_chk_d   = w_dec.chk_ovf;
      s1_ill_d   = w_dec.illegal;
    end else if (w_xfer) begin
      s1_valid_d = 1'b0;
    end

    if (w_xfer) begin
      s2_valid_d = 1'b1;
      s2_res_d   = alu_out;
      s2_rd_d    = s1_rd_q;
      s2_ovf_d   = s1_chk_q && alu_overflow;
      s2_ill_d   = s1_ill_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_in1_q   <= '0;
      s1_in2_q   <= '0;
      s1_sel_q   <= SEL_ADD;
      s1_rd_q    <= '0;
      s1_chk_q   <= 1'b0;
      s1_ill_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_rd_q    <= '0;
      s2_ovf_q   <= 1'b0;
      s2_ill_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_in1_q   <= s1_in1_d;
      s1_in2_q   <= s1_in2_d;
      s1_sel_q   <= s1_sel_d;
      s1_rd_q    <= s1_rd_d;
      s1_chk_q   <= s1_chk_d;
      s1_ill_q   <= s1_ill_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_rd_q    <= s2_rd_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_ill_q   <= s2_ill_d;
    end
  end

  assign alu_in1      = s1_in1_q;
  assign alu_in2      = s1_in2_q;
  assign alu_sel      = s1_sel_q;
  assign out_valid    = s2_valid_q;
  assign out_result   = s2_res_q;
  assign out_rd       = s2_rd_q;
  assign out_overflow = s2_ovf_q;
  assign out_illegal  = s2_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_dlx_ex_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlx_ex_issue
// Purpose  : Self-checking bench for dlx_ex_issue with an attached ALU model
//            and an instruction-level scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dlx_ex_issue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  opcode, func;
  logic [31:0] rs1_val, rs2_val, alu_in1, alu_in2, alu_out, out_result;
  logic [15:0] imm16;
  logic [4:0]  rd, out_rd, alu_sel;
  logic        alu_overflow, out_overflow, out_illegal;
  logic [31:0] w_sum, w_dif;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dlx_ex_issue #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func(func), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm16(imm16), .rd(rd),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_overflow(out_overflow), .out_illegal(out_illegal)
  );

  // Combinational arithmetic ALU driven by the select lines
  always_comb begin
    w_sum        = alu_in1 + alu_in2;
    w_dif        = alu_in1 - alu_in2;
    alu_out      = 32'hDEADBEEF;
    alu_overflow = 1'b0;
    case (alu_sel)
      5'b00000: begin
        alu_out      = w_sum;
        alu_overflow = (alu_in1[31] == alu_in2[31]) && (w_sum[31] != alu_in1[31]);
      end
      5'b11000: begin
        alu_out      = w_dif;
        alu_overflow = (alu_in1[31] != alu_in2[31]) && (w_dif[31] != alu_in1[31]);
      end
      5'b10000: alu_out = {31'd0, alu_in1 == alu_in2};
      5'b10001: alu_out = {31'd0, alu_in1 != alu_in2};
      5'b10010: alu_out = {31'd0, $signed(alu_in1) <  $signed(alu_in2)};
      5'b10011: alu_out = {31'd0, $signed(alu_in1) >  $signed(alu_in2)};
      5'b10100: alu_out = {31'd0, $signed(alu_in1) <= $signed(alu_in2)};
      5'b10110: alu_out = {31'd0, $signed(alu_in1) >= $signed(alu_in2)};
      default:  alu_out = 32'hDEADBEEF;
    endcase
  end

  // Instruction-level reference: what an op must produce when it retires
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b2,
                                 input logic [15:0] im, input logic [4:0] r);
    exp_t e;
    int kind; // 0 add, 1 sub, 2 seq, 3 sne, 4 slt, 5 sgt, 6 sle, 7 sge
    bit signed_chk, zext, ill;
    logic [31:0] b, res;
    kind = 0; signed_chk = 0; zext = 0; ill = 0;
    if (op == 6'h00) begin
      if (fn == 6'h20) begin kind = 0; signed_chk = 1; end
      else if (fn == 6'h21) kind = 0;
      else if (fn == 6'h22) begin kind = 1; signed_chk = 1; end
      else if (fn == 6'h23) kind = 1;
      else if (fn >= 6'h28 && fn <= 6'h2D) kind = int'(fn) - 'h28 + 2;
      else ill = 1;
      b = b2;
    end else begin
      if (op == 6'h08) begin kind = 0; signed_chk = 1; end
      else if (op == 6'h09) begin kind = 0; zext = 1; end
      else if (op == 6'h0A) begin kind = 1; signed_chk = 1; end
      else if (op == 6'h0B) begin kind = 1; zext = 1; end
      else if (op >= 6'h18 && op <= 6'h1D) kind = int'(op) - 'h18 + 2;
      else ill = 1;
      b = zext ? {16'h0, im} : {{16{im[15]}}, im};
    end
    case (kind)
      0: res = a + b;
      1: res = a - b;
      2: res = 32'(a == b);
      3: res = 32'(a != b);
      4: res = 32'($signed(a) <  $signed(b));
      5: res = 32'($signed(a) >  $signed(b));
      6: res = 32'($signed(a) <= $signed(b));
      default: res = 32'($signed(a) >= $signed(b));
    endcase
    e.res = res;
    e.rd  = r;
    e.ill = ill;
    if (!signed_chk)  e.ovf = 1'b0;
    else if (kind == 0) e.ovf = (a[31] == b[31]) && (res[31] != a[31]);
    else              e.ovf = (a[31] != b[31]) && (res[31] != a[31]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: score the handshakes seen before the edge, then check holds
  task automatic step(output bit acc);
    bit fire, hold, stall;
    logic [31:0] h_res, h_in1, h_in2;
    logic [4:0]  h_rd, h_sel;
    logic        h_ovf, h_ill;
    exp_t        e;
    @(negedge clk);
    acc   = in_valid && in_ready && rst_n && !flush;
    fire  = out_valid && out_ready && rst_n && !flush;
    hold  = out_valid && !out_ready && rst_n && !flush;
    stall = !in_ready && rst_n && !flush;
    h_res = out_result; h_rd = out_rd; h_ovf = out_overflow; h_ill = out_illegal;
    h_in1 = alu_in1; h_in2 = alu_in2; h_sel = alu_sel;
    if (fire) begin
      if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_result", out_result, e.res);
        chk("sb_rd", 32'(out_rd), 32'(e.rd));
        chk("sb_ovf", 32'(out_overflow), 32'(e.ovf));
        chk("sb_ill", 32'(out_illegal), 32'(e.ill));
      end
    end
    if (!rst_n || flush) sb.delete();
    else if (acc) sb.push_back(model(opcode, func, rs1_val, rs2_val, imm16, rd));
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, h_res);
      chk("hold_flags", {25'd0, out_rd, out_overflow, out_illegal}, {25'd0, h_rd, h_ovf, h_ill});
    end
    if (stall) begin
      chk("stall_in1", alu_in1, h_in1);
      chk("stall_in2", alu_in2, h_in2);
      chk("stall_sel", 32'(alu_sel), 32'(h_sel));
    end
  endtask

  task automatic set_op(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] im, input logic [4:0] r);
    opcode = op; func = fn; rs1_val = a; rs2_val = b; imm16 = im; rd = r;
    in_valid = 1'b1;
  endtask

  // Present an op and keep it valid until accepted
  task automatic offer(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] im, input logic [4:0] r);
    bit acc;
    int tries;
    set_op(op, fn, a, b, im, r);
    tries = 0;
    acc = 0;
    while (!acc && tries < 20) begin
      step(acc);
      tries++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, {out_valid, out_overflow, out_illegal, out_rd}, 32'd0);
    chk({tag, "_res"}, out_result, 32'd0);
    chk({tag, "_in1"}, alu_in1, 32'd0);
    chk({tag, "_in2"}, alu_in2, 32'd0);
    chk({tag, "_sel"}, 32'(alu_sel), 32'd0);
  endtask

  logic [4:0] set_sel [6];
  logic [5:0] rfn [10];
  logic [5:0] iop [10];

  initial begin
    bit acc;
    int k;
    logic [31:0] a, b;
    set_sel = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10110};
    rfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D};
    iop = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D};

    // Reset state
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; func = '0; rs1_val = '0; rs2_val = '0; imm16 = '0; rd = '0;
    idle(2);
    chk_zero("reset");
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    idle(1);

    // R-type ADD 1+1
    offer(6'h00, 6'h20, 32'd1, 32'd1, 16'h0, 5'd3);
    chk("add_sel", 32'(alu_sel), 32'd0);
    chk("add_in1", alu_in1, 32'd1);
    chk("add_valid_early", 32'(out_valid), 32'd0);
    idle(1);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_result", out_result, 32'd2);
    chk("add_flags", {out_overflow, out_illegal}, 32'd0);
    idle(2);

    // Back-to-back set ops with equal operands
    for (int i = 0; i < 6; i++) begin
      offer(6'h00, 6'h28 + 6'(i), 32'd1, 32'd1, 16'h0, 5'(i + 1));
      chk("set_sel", 32'(alu_sel), 32'(set_sel[i]));
    end
    idle(3);

    // Overflow masking and immediate extension
    offer(6'h08, 6'h00, 32'h7FFFFFFF, 32'd0, 16'h0001, 5'd4);
    idle(1);
    chk("addi_ovf", 32'(out_overflow), 32'd1);
    offer(6'h09, 6'h00, 32'h7FFFFFFF, 32'd0, 16'h0001, 5'd5);
    idle(1);
    chk("addui_ovf", 32'(out_overflow), 32'd0);
    offer(6'h0B, 6'h00, 32'd5, 32'd0, 16'hFFFF, 5'd6);
    chk("subui_in2", alu_in2, 32'h0000FFFF);
    idle(2);

    // Backpressure: three ops, output stalled
    out_ready = 1'b0;
    offer(6'h00, 6'h20, 32'd10, 32'd20, 16'h0, 5'd7);
    offer(6'h00, 6'h22, 32'd50, 32'd8, 16'h0, 5'd8);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    set_op(6'h1A, 6'h00, 32'd3, 32'd0, 16'h0009, 5'd9);
    step(acc);
    chk("bp_no_accept", 32'(acc), 32'd0);
    chk("bp_first_held", out_result, 32'd30);
    step(acc);
    chk("bp_no_accept2", 32'(acc), 32'd0);
    out_ready = 1'b1;
    offer(6'h1A, 6'h00, 32'd3, 32'd0, 16'h0009, 5'd9);
    idle(4);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Flush with both stages full and a same-cycle offer
    out_ready = 1'b0;
    offer(6'h00, 6'h21, 32'd1, 32'd2, 16'h0, 5'd10);
    offer(6'h00, 6'h21, 32'd3, 32'd4, 16'h0, 5'd11);
    set_op(6'h00, 6'h21, 32'd5, 32'd6, 16'h0, 5'd12);
    flush = 1'b1;
    step(acc);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    idle(3);
    chk("flush_no_ghost", 32'(out_valid), 32'd0);

    // Unsupported opcode executes as rs1+imm and flags illegal
    offer(6'h3F, 6'h00, 32'd5, 32'd99, 16'h0003, 5'd13);
    idle(1);
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    chk("illegal_result", out_result, 32'd8);
    idle(1);

    // Randomized traffic with random backpressure and rare flushes
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 21));
      a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 32'h7FFFFFFF : 32'h80000000) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (k < 10)       set_op(6'h00, rfn[k], a, b, 16'($urandom), 5'($urandom));
      else if (k < 20)  set_op(iop[k - 10], 6'($urandom), a, b, 16'($urandom), 5'($urandom));
      else if (k == 20) set_op(6'h3F, 6'h00, a, b, 16'($urandom), 5'($urandom));
      else              set_op(6'h00, 6'h3F, a, b, 16'($urandom), 5'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      step(acc);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(4);
    chk("rand_drained", 32'(sb.size()), 32'd0);

    // Reset mid-stream drops in-flight ops
    out_ready = 1'b0;
    offer(6'h08, 6'h00, 32'd7, 32'd0, 16'h0002, 5'd14);
    offer(6'h08, 6'h00, 32'd9, 32'd0, 16'h0002, 5'd15);
    rst_n = 1'b0;
    idle(1);
    chk_zero("midrst");
    rst_n = 1'b1; out_ready = 1'b1;
    idle(3);
    chk("midrst_no_out", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
